serial_add_ctrl: RTL and testbench

//  Bit-serial add/subtract sequencer built around one FullAdder instance.

---
 rtl/serial_add_ctrl.sv | 139 +++++++++++++
 tb/tb_serial_add_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one 1-bit full adder walks two
// WIDTH-bit operands LSB-first, with a registered carry between bits.
module serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CW-1:0] CNT_MSB  = CW'(WIDTH - 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    count_q, count_d;
    logic             carry_q, carry_d;
    logic             c_msb_q, c_msb_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic fa_s;
    logic fa_c;

    full_adder u_full_adder (
        .a  (op_a_q[0]),
        .b  (op_b_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_c)
    );

    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        sum_d   = sum_q;
        count_d = count_q;
        carry_d = carry_q;
        c_msb_d = c_msb_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    // subtraction is a + ~b + 1, so sub needs no later storage
                    op_a_d  = a;
                    op_b_d  = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    count_d = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                op_a_d  = op_a_q >> 1;
                op_b_d  = op_b_q >> 1;
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                carry_d = fa_c;
                count_d = count_q + CW'(1);
                if (count_q == CNT_MSB) begin
                    c_msb_d = fa_c;
                end
                if (count_q == CNT_LAST) begin
                    cout_d  = fa_c;
                    ovf_d   = c_msb_q ^ fa_c;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            sum_q   <= '0;
            count_q <= '0;
            carry_q <= 1'b0;
            c_msb_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            sum_q   <= sum_d;
            count_q <= count_d;
            carry_q <= carry_d;
            c_msb_q <= c_msb_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=16 with hand-computed
// sums, carries, overflow flags, latency and mid-run events.
module tb_serial_add_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         sub;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;

    int n_checks = 0;
    int n_fail   = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .sub      (sub),
        .cin      (cin),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // inject: 0 none, 1 start pulse at run cycle 5, 2 reset at run cycle 8
    task automatic run_op(input string tag, input logic [W-1:0] ia,
                          input logic [W-1:0] ib, input logic isub,
                          input logic icin, input logic [W-1:0] es,
                          input logic ec, input logic eo, input int inject);
        int lat;
        a = ia;
        b = ib;
        sub = isub;
        cin = icin;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, " busy"}, 32'(busy), 32'd1);
        lat = 0;
        while (!done && lat < 40) begin
            if (inject == 1 && lat == 5) begin
                start = 1'b1;
                a = 16'hFFFF;
                b = 16'hFFFF;
                sub = 1'b1;
                cin = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (inject == 2 && lat == 8) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                check({tag, " rst busy"}, 32'(busy), 32'd0);
                check({tag, " rst done"}, 32'(done), 32'd0);
                check({tag, " rst sum"}, 32'(sum), 32'd0);
                check({tag, " rst cout"}, 32'(cout), 32'd0);
                check({tag, " rst ovf"}, 32'(overflow), 32'd0);
                return;
            end
            tick();
            lat++;
        end
        start = 1'b0;
        check({tag, " latency"}, 32'(lat), 32'(W));
        check({tag, " sum"}, 32'(sum), 32'(es));
        check({tag, " cout"}, 32'(cout), 32'(ec));
        check({tag, " ovf"}, 32'(overflow), 32'(eo));
        tick();
        check({tag, " idle done"}, 32'(done), 32'd0);
        check({tag, " idle busy"}, 32'(busy), 32'd0);
        check({tag, " held sum"}, 32'(sum), 32'(es));
        check({tag, " held ovf"}, 32'(overflow), 32'(eo));
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        sub = 1'b0;
        cin = 1'b0;
        a = '0;
        b = '0;
        @(negedge clk);
        tick();
        reset = 1'b0;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset sum", 32'(sum), 32'd0);
        check("reset cout", 32'(cout), 32'd0);
        check("reset ovf", 32'(overflow), 32'd0);

        run_op("add1", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 0);
        run_op("addc", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
        run_op("addv", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
        run_op("cin1", 16'h00FF, 16'h0100, 1'b0, 1'b1, 16'h0200, 1'b0, 1'b0, 0);
        run_op("sub1", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0);
        run_op("subv", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 0);
        run_op("rst", 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 2);
        run_op("post", 16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0, 1'b0, 0);
        run_op("ign", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1);

        // start held high: one idle cycle separates DONE and the next RUN
        a = 16'h0001;
        b = 16'h0002;
        sub = 1'b0;
        cin = 1'b0;
        start = 1'b1;
        tick();
        repeat (W) tick();
        check("hold done", 32'(done), 32'd1);
        check("hold sum", 32'(sum), 32'h0003);
        a = 16'h0004;
        b = 16'h0004;
        tick();
        check("hold idle", 32'(busy), 32'd0);
        tick();
        start = 1'b0;
        check("hold accept", 32'(busy), 32'd1);
        repeat (W) tick();
        check("hold done2", 32'(done), 32'd1);
        check("hold sum2", 32'(sum), 32'h0008);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
